// File: rtl/uart_tx_engine.sv
// UART transmitter driven by a 16x oversampling tick: start bit, DBIT data bits LSB-first, stop period.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop period.
module uart_tx_engine #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tx_start,
   input  logic            s_tick,
   input  logic [DBIT-1:0] din,
   output logic            tx_busy,
   output logic            tx_done_tick,
   output logic            tx
);

   // Tick counter must reach SB_TICK-1 during the stop period, and 15 elsewhere.
   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic parity_reg, parity_next;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state_reg, state_next;
   logic [SW-1:0]   s_reg, s_next;
   logic [2:0]      n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            tx_reg, tx_next;
   logic            done_reg, done_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         s_reg      <= '0;
         n_reg      <= '0;
         b_reg      <= '0;
         tx_reg     <= 1'b1;
         done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         s_reg      <= s_next;
         n_reg      <= n_next;
         b_reg      <= b_next;
         tx_reg     <= tx_next;
         done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
         parity_reg <= parity_next;
`endif
      end
   end

   // tx is computed one edge ahead so the line changes exactly on the bit-boundary edge.
   always_comb begin
      state_next  = state_reg;
      s_next      = s_reg;
      n_next      = n_reg;
      b_next      = b_reg;
      tx_next     = tx_reg;
      done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_reg;
`endif
      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (tx_start) begin
               state_next  = START;
               s_next      = '0;
               b_next      = din;
               tx_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
               parity_next = ^din;
`endif
            end
         end
         START: begin
            if (s_tick) begin
               if (s_reg == SW'(15)) begin
                  state_next = DATA;
                  s_next     = '0;
                  n_next     = '0;
                  tx_next    = b_reg[0];
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_reg == SW'(15)) begin
                  s_next = '0;
                  b_next = b_reg >> 1;
                  if (n_reg == 3'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                     state_next = PARITY;
                     tx_next    = parity_reg;
`else
                     state_next = STOP;
                     tx_next    = 1'b1;
`endif
                  end else begin
                     n_next  = n_reg + 3'd1;
                     tx_next = b_reg[1];
                  end
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s_reg == SW'(15)) begin
                  state_next = STOP;
                  s_next     = '0;
                  tx_next    = 1'b1;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
`endif
         STOP: begin
            tx_next = 1'b1;
            if (s_tick) begin
               if (s_reg == SW'(SB_TICK - 1)) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   assign tx_busy      = (state_reg != IDLE);
   assign tx_done_tick = done_reg;
   assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine (SB_TICK=16 instance plus an SB_TICK=32 instance).
// Expectations follow UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_tx_engine;

   localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
   localparam int PEN = 1;
`else
   localparam int PEN = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_start;
   logic       s_tick;
   logic [7:0] din;
   logic       tx_busy, tx_done_tick, tx;

   logic       tx_start32;
   logic [7:0] din32;
   logic       tx_busy32, tx_done_tick32, tx32;

   int         tick_period = 1;
   logic [7:0] tick_cnt = 8'd0;
   int         tests_run = 0;
   int         fail_count = 0;

   uart_tx_engine #(.DBIT(DBIT), .SB_TICK(16)) dut (
      .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
      .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
   );

   uart_tx_engine #(.DBIT(DBIT), .SB_TICK(32)) dut32 (
      .clk(clk), .reset(reset), .tx_start(tx_start32), .s_tick(s_tick), .din(din32),
      .tx_busy(tx_busy32), .tx_done_tick(tx_done_tick32), .tx(tx32)
   );

   always #5 clk = ~clk;

   // Modulo-P tick generator; period 1 means s_tick is tied high.
   always @(posedge clk)
      tick_cnt <= (int'(tick_cnt) >= tick_period - 1) ? 8'd0 : tick_cnt + 8'd1;
   assign s_tick = (tick_period == 1) || (int'(tick_cnt) == tick_period - 1);

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after the accepting edge; returns #1 after the edge that raises tx_done_tick.
   task automatic capture_frame(input string tag, input logic [7:0] data, input int p, input bit interfere);
      int         done_exp;
      int         early;
      logic [7:0] rx;
      done_exp = p * (16 * (1 + DBIT + PEN) + 16);
      early    = 0;
      rx       = 8'h00;
      for (int cyc = 0; cyc <= done_exp; cyc++) begin
         if (cyc > 0) step();
         if (cyc < done_exp && tx_done_tick) early++;
         if (cyc == 8 * p) begin
            check_output({tag, "_start_bit"}, tx, 1'b0);
            check_output({tag, "_busy_mid"}, tx_busy, 1'b1);
         end
         for (int i = 1; i <= DBIT; i++)
            if (cyc == 16 * p * i + 8 * p) rx[i-1] = tx;
`ifdef UART_TX_PARITY_EN
         if (cyc == 16 * p * (1 + DBIT) + 8 * p)
            check_output({tag, "_parity"}, tx, ^data);
`endif
         if (cyc == 16 * p * (1 + DBIT + PEN) + 8 * p)
            check_output({tag, "_stop_bit"}, tx, 1'b1);
         if (interfere && cyc == 48 * p) begin
            din      = 8'hFF;
            tx_start = 1'b1;
         end
         if (interfere && cyc == 48 * p + 2) tx_start = 1'b0;
      end
      check_output({tag, "_data"}, rx, data);
      check_output({tag, "_no_early_done"}, early, 0);
      check_output({tag, "_done_at_end"}, tx_done_tick, 1'b1);
      check_output({tag, "_idle_at_done"}, tx_busy, 1'b0);
   endtask

   task automatic send_frame(input string tag, input logic [7:0] data, input int p, input bit hold, input bit interfere);
      tick_period = p;
      din         = data;
      for (int k = 0; k < p + 2 && int'(tick_cnt) != p - 1; k++) step();
      tx_start = 1'b1;
      step();
      if (!hold) tx_start = 1'b0;
      check_output({tag, "_line_falls"}, tx, 1'b0);
      capture_frame(tag, data, p, interfere);
   endtask

   task automatic check_after_done(input string tag);
      step();
      check_output({tag, "_done_one_cycle"}, tx_done_tick, 1'b0);
      check_output({tag, "_stays_idle"}, tx_busy, 1'b0);
   endtask

   task automatic apply_stimulus();
      int done_seen;
      int low_seen;
      int done_at;

      reset = 1'b1; tx_start = 1'b0; din = 8'h00; tx_start32 = 1'b0; din32 = 8'h00;
      step();
      step();
      check_output("rst_tx", tx, 1'b1);
      check_output("rst_busy", tx_busy, 1'b0);
      check_output("rst_done", tx_done_tick, 1'b0);
      check_output("rst_tx32", tx32, 1'b1);
      reset = 1'b0;
      step();

      send_frame("f55", 8'h55, 1, 1'b0, 1'b0);
      check_after_done("f55");

      send_frame("fa3", 8'hA3, 4, 1'b0, 1'b0);
      check_after_done("fa3");

      send_frame("ignore", 8'h3C, 1, 1'b0, 1'b1);
      check_after_done("ignore");

      // Back-to-back: tx_start held through the done cycle.
      send_frame("b2b0", 8'h00, 1, 1'b1, 1'b0);
      check_output("b2b_gap_high", tx, 1'b1);
      din = 8'h81;
      step();
      check_output("b2b_second_start", tx, 1'b0);
      check_output("b2b_second_busy", tx_busy, 1'b1);
      tx_start = 1'b0;
      capture_frame("b2b1", 8'h81, 1, 1'b0);
      check_after_done("b2b1");

      // Asynchronous reset in the middle of the data bits.
      tick_period = 1;
      din = 8'h3C;
      tx_start = 1'b1;
      step();
      tx_start = 1'b0;
      repeat (40) step();
      check_output("mid_busy_before_rst", tx_busy, 1'b1);
      reset = 1'b1;
      #2;
      check_output("mid_rst_tx", tx, 1'b1);
      check_output("mid_rst_busy", tx_busy, 1'b0);
      step();
      reset = 1'b0;
      done_seen = 0;
      low_seen  = 0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (tx_done_tick) done_seen++;
         if (!tx) low_seen++;
      end
      check_output("mid_rst_no_done", done_seen, 0);
      check_output("mid_rst_line_idle", low_seen, 0);
      send_frame("post_rst", 8'h96, 1, 1'b0, 1'b0);
      check_after_done("post_rst");

      // Two stop bits on the SB_TICK=32 instance.
      tick_period = 1;
      din32 = 8'h55;
      tx_start32 = 1'b1;
      step();
      tx_start32 = 1'b0;
      done_at = -1;
      for (int c = 1; c <= 400 && done_at < 0; c++) begin
         step();
         if (c == 170 + 16 * PEN) check_output("sb32_busy_in_stop", tx_busy32, 1'b1);
         if (c == 170 + 16 * PEN) check_output("sb32_tx_in_stop", tx32, 1'b1);
         if (tx_done_tick32) done_at = c;
      end
      check_output("sb32_done_cycle", done_at, 176 + 16 * PEN);
   endtask

   initial begin
      apply_stimulus();
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Serial transmitter that consumes the baud-rate tick stream produced by the design's modulo-M tick generator. That generator is configured for 16x oversampling.
- Accepts one parallel byte per request and shifts it out LSB-first on a single line.
- Frame format: start bit, DBIT data bits, optional parity bit, stop bit(s).
- Sits between game/control logic and the board's serial TX pin. It is the transmit-side counterpart to the tick generator and UART receive path.

Parameters:
DBIT, 8, number of data bits per frame (legal 5..8)
SB_TICK, 16, s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
tx_start  input  1  request to send din; sampled only in IDLE
s_tick  input  1  one-cycle oversampling tick (16 per bit period) from the tick generator
din  input  DBIT  data byte to send; captured on the accepting edge
tx_busy  output  1  high whenever state != IDLE
tx_done_tick  output  1  one-cycle pulse at end of stop period
tx  output  1  serial line, registered, idle-high

Behaviour:
- Reset (async, any time including mid-frame):
  - state=IDLE, tick counter s=0, bit counter n=0, shift reg b=0.
  - tx=1, tx_busy=0, tx_done_tick=0.
  - A partial frame is abandoned; no done pulse is issued.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
  - Tick counter s is 4 bits wide for the START, DATA and PARITY states, wide enough for SB_TICK-1 in STOP.
  - Bit counter n is 3 bits.
- IDLE:
  - tx=1.
  - If tx_start=1, on that edge: b<=din, s<=0, state<=START, tx<=0 (line falls on the accepting edge).
  - s_tick is irrelevant in IDLE.
- START:
  - On s_tick with s=15: s<=0, n<=0, state<=DATA, tx<=b[0].
  - Else on s_tick: s<=s+1.
  - No s_tick: hold.
- DATA:
  - On s_tick with s=15: s<=0 and b<=b>>1.
  - If n=DBIT-1, go to STOP (or PARITY), tx<=1 (or parity bit). Otherwise n<=n+1 and tx<=next b[0].
  - Else on s_tick: s<=s+1.
- STOP:
  - tx=1.
  - On s_tick with s=SB_TICK-1: state<=IDLE, tx_done_tick<=1 for exactly one cycle.
  - Else on s_tick: s<=s+1.
- Each bit lasts exactly 16 s_ticks; the stop period lasts SB_TICK s_ticks.
- tx_start while busy is ignored (no queueing). din changes after the accepting edge have no effect.
- Back-to-back sends: tx_start held high during the done cycle is accepted on the next edge. The minimum idle gap is 1 clock with tx=1.
- s_tick coincident with the accepting edge in IDLE is not counted.
- tx_busy is combinational from state. tx and tx_done_tick are registered.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of all DBIT data bits, computed at capture) for 16 s_ticks.
  - Frame length grows by 16 ticks.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset mid-frame: reset pulsed while in DATA → tx=1 and tx_busy=0 immediately (asynchronous), no tx_done_tick. The next tx_start sends a full frame.
- s_tick tied 1, din=0x55, tx_start pulsed 1 cycle → tx low cycles 1–16, then data bits 1,0,1,0,1,0,1,0 each 16 cycles, then high 16 cycles. tx_done_tick is high for exactly one cycle, 160 cycles after acceptance. With macro: parity bit 0 precedes stop and done occurs at 176.
- s_tick every 4th cycle (mod-4 generator), din=0xA3 → each bit 64 cycles. Sampling tx mid-bit recovers 0xA3 LSB-first. With macro the parity bit is 0; done occurs 640 cycles after acceptance (704 with macro).
- tx_start re-asserted and din changed to 0xFF mid-frame → ignored. The line still carries the original byte, and only one tx_done_tick occurs.
- tx_start held high continuously, din=0x00 then 0x81 → two consecutive frames. Exactly 1 idle-high cycle between stop end and the next start bit; two done pulses.
- SB_TICK=32 build, s_tick=1 → stop period 32 cycles, done at cycle 176.
